// File: rtl/fetch_stack.sv
// fetch_stack: prefills the three top-of-stack registers from block RAM after reset.
//
// state  | meaning
// -------+-------------------------------------------------------------
// FETCH1 | dataOut holds ram[sp]; capture topOfStack1, address sp+1
// FETCH2 | dataOut holds ram[sp+1]; capture topOfStack2, address sp+2
// FETCH3 | dataOut holds ram[sp+2]; capture topOfStack3, raise finished
// DONE   | all words captured; hold until next reset
//
// While reset is low the address already points at stackPointer, so the
// first word is waiting on dataOut at the first edge after release.
module fetch_stack #(
  parameter int addrBits = 16,
  parameter int dataBits = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [dataBits-1:0] dataOut,
  output logic [addrBits-1:0] address,
  output logic                finished,
  input  logic [addrBits-1:0] stackPointer,
  output logic [dataBits-1:0] topOfStack1,
  output logic [dataBits-1:0] topOfStack2,
  output logic [dataBits-1:0] topOfStack3
);

  localparam logic [1:0] FETCH1 = 2'd0;
  localparam logic [1:0] FETCH2 = 2'd1;
  localparam logic [1:0] FETCH3 = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [dataBits-1:0] tos1_q, tos1_d;
  logic [dataBits-1:0] tos2_q, tos2_d;
  logic [dataBits-1:0] tos3_q, tos3_d;
  logic                fin_q, fin_d;

  // Next-state and capture logic: one word per cycle, then park in DONE.
  always_comb begin
    state_d = state_q;
    tos1_d  = tos1_q;
    tos2_d  = tos2_q;
    tos3_d  = tos3_q;
    fin_d   = fin_q;
    case (state_q)
      FETCH1: begin
        tos1_d  = dataOut;
        state_d = FETCH2;
      end
      FETCH2: begin
        tos2_d  = dataOut;
        state_d = FETCH3;
      end
      FETCH3: begin
        tos3_d  = dataOut;
        fin_d   = 1'b1;
        state_d = DONE;
      end
      default: ;
    endcase
  end

  // RAM address: prefetch the base during reset, then run one word ahead.
  always_comb begin
    if (!reset) begin
      address = stackPointer;
    end else begin
      case (state_q)
        FETCH1:  address = stackPointer + addrBits'(1);
        default: address = stackPointer + addrBits'(2);
      endcase
    end
  end

  // State and captured words; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH1;
      tos1_q  <= '0;
      tos2_q  <= '0;
      tos3_q  <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tos1_q  <= tos1_d;
      tos2_q  <= tos2_d;
      tos3_q  <= tos3_d;
      fin_q   <= fin_d;
    end
  end

  assign topOfStack1 = tos1_q;
  assign topOfStack2 = tos2_q;
  assign topOfStack3 = tos3_q;
  assign finished    = fin_q;

endmodule

// File: tb/tb_fetch_stack.sv
// Directed bench for fetch_stack with a synchronous-read RAM model.
module tb_fetch_stack;

  logic        clk;
  logic        reset;
  logic [15:0] dataOut;
  logic [15:0] address;
  logic        finished;
  logic [15:0] stackPointer;
  logic [15:0] topOfStack1, topOfStack2, topOfStack3;

  logic [15:0] ram [0:65535];

  int n_tests = 0;
  int n_fail  = 0;

  fetch_stack #(.addrBits(16), .dataBits(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .dataOut      (dataOut),
    .address      (address),
    .finished     (finished),
    .stackPointer (stackPointer),
    .topOfStack1  (topOfStack1),
    .topOfStack2  (topOfStack2),
    .topOfStack3  (topOfStack3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM: data reflects the address sampled at the edge.
  always @(posedge clk) dataOut <= ram[address];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input logic [15:0] t1, input logic [15:0] t2,
                            input logic [15:0] t3, input logic fin);
    check({tag, ".tos1"}, {16'h0, topOfStack1}, {16'h0, t1});
    check({tag, ".tos2"}, {16'h0, topOfStack2}, {16'h0, t2});
    check({tag, ".tos3"}, {16'h0, topOfStack3}, {16'h0, t3});
    check({tag, ".fin"},  {31'h0, finished},    {31'h0, fin});
  endtask

  initial begin
    reset        = 1'b0;
    stackPointer = 16'd8;
    ram[8]  = 16'h1111; ram[9] = 16'h2222; ram[10] = 16'h3333;
    ram[16'hFFFF] = 16'hAAAA; ram[0] = 16'hBBBB; ram[1] = 16'hCCCC;
    ram[20] = 16'd1; ram[21] = 16'd2; ram[22] = 16'd3;

    // Reset values, no prior fetch
    #1;
    check_outs("rst", 16'h0, 16'h0, 16'h0, 1'b0);
    check("rst.addr", {16'h0, address}, 32'd8);

    // Basic fetch with per-edge checks
    tick(); tick();
    check("basic.addr_rst", {16'h0, address}, 32'd8);
    reset = 1'b1;
    #1;
    check("basic.addr_f1", {16'h0, address}, 32'd9);
    tick();
    check_outs("edge1", 16'h1111, 16'h0, 16'h0, 1'b0);
    check("edge1.addr", {16'h0, address}, 32'd10);
    tick();
    check_outs("edge2", 16'h1111, 16'h2222, 16'h0, 1'b0);
    check("edge2.addr", {16'h0, address}, 32'd10);
    tick();
    check_outs("edge3", 16'h1111, 16'h2222, 16'h3333, 1'b1);
    check("edge3.addr", {16'h0, address}, 32'd10);

    // Hold in DONE while RAM changes
    ram[8] = 16'h4444; ram[9] = 16'h5555; ram[10] = 16'h6666;
    for (int i = 0; i < 10; i++) tick();
    check_outs("hold", 16'h1111, 16'h2222, 16'h3333, 1'b1);

    // Reset from DONE clears at once; then wrap-around fetch
    reset = 1'b0;
    #1;
    check_outs("rst_done", 16'h0, 16'h0, 16'h0, 1'b0);
    stackPointer = 16'hFFFF;
    #1;
    check("wrap.addr_rst", {16'h0, address}, 32'hFFFF);
    tick();
    reset = 1'b1;
    #1;
    check("wrap.addr_f1", {16'h0, address}, 32'h0000);
    tick(); tick(); tick();
    check_outs("wrap", 16'hAAAA, 16'hBBBB, 16'hCCCC, 1'b1);
    check("wrap.addr_done", {16'h0, address}, 32'h0001);

    // Reset mid-fetch, restart from a new base
    reset = 1'b0;
    stackPointer = 16'd8;
    tick();
    reset = 1'b1;
    tick();
    check_outs("mid.edge1", 16'h4444, 16'h0, 16'h0, 1'b0);
    reset = 1'b0;
    #1;
    check_outs("mid.rst", 16'h0, 16'h0, 16'h0, 1'b0);
    stackPointer = 16'd20;
    tick();
    reset = 1'b1;
    tick(); tick();
    check_outs("mid.edge2", 16'd1, 16'd2, 16'h0, 1'b0);
    tick();
    check_outs("mid.done", 16'd1, 16'd2, 16'd3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stack.md
# fetch_stack

Stack-cache prefill engine for the stack processor core. After reset is released, it reads the three memory words at `stackPointer`, `stackPointer+1` and `stackPointer+2` from the single-port block RAM (IceRam). It loads them into the top-of-stack registers `topOfStack1..3` and raises `finished`. The block drives only the RAM address; the RAM read/write select is tied to read by the enclosing design.

## Interface

Parameters:
- `addrBits`, default 16: RAM address width, and width of `stackPointer`.
- `dataBits`, default 16: RAM word width, and width of each top-of-stack register.

Ports:
- `clk`, input, 1: single clock; everything is rising-edge.
- `reset`, input, 1: asynchronous, active-low reset. Low means held in reset; high means run.
- `dataOut`, input, `dataBits`: read data from the RAM, valid one cycle after its address.
- `address`, output, `addrBits`: RAM read address.
- `finished`, output, 1: high once all three words are captured.
- `stackPointer`, input, `addrBits`: base address of the stack top.
- `topOfStack1`, output, `dataBits`: word at `stackPointer`.
- `topOfStack2`, output, `dataBits`: word at `stackPointer+1`.
- `topOfStack3`, output, `dataBits`: word at `stackPointer+2`.

## Operation

- RAM contract: synchronous read. `dataOut` after rising edge N equals `ram[address sampled at edge N]`. The block never writes.
- State register `state`, 2 bits: FETCH1 (0), FETCH2 (1), FETCH3 (2), DONE (3). Reset forces FETCH1.
- Address is combinational:
  - While `reset` is low: `address = stackPointer`. This is a prefetch, so `dataOut` already holds `ram[stackPointer]` on the first edge after release.
  - FETCH1: `stackPointer+1`.
  - FETCH2: `stackPointer+2`.
  - FETCH3 and DONE: `stackPointer+2`.
- Each rising edge while `reset` is high:
  - FETCH1: `topOfStack1 <= dataOut`, then go to FETCH2.
  - FETCH2: `topOfStack2 <= dataOut`, then go to FETCH3.
  - FETCH3: `topOfStack3 <= dataOut`, set `finished <= 1`, then go to DONE.
  - DONE: hold all registers. `finished` stays 1 until the next reset.
- Address arithmetic is modulo 2^`addrBits`. Wrap-around is silent, e.g. `stackPointer = 0xFFFF` reads 0xFFFF, 0x0000, 0x0001.
- `stackPointer` must be stable from reset assertion until `finished`. The block does not latch it.

## Timing

- Reset values: `topOfStack1..3 = 0`, `finished = 0`, state FETCH1. These are applied immediately (asynchronous) when `reset` goes low.
- `reset` must be held low for at least one rising edge of `clk` with `stackPointer` stable, so the prefetch completes.
- Latency: the three registers are loaded on rising edges 1, 2 and 3 after `reset` goes high. `finished` goes high on edge 3, in the same cycle `topOfStack3` becomes valid.
- Reset asserted mid-fetch: outputs clear at once. On release the whole fetch restarts from FETCH1. No partial values survive.
- Reset asserted in DONE: same as mid-fetch; the fetch repeats on release.
- One word is captured per cycle. There is no stall input and no handshake beyond `finished`.

## Test plan

- Basic fetch: `ram[8..10] = 0x1111, 0x2222, 0x3333`, `stackPointer = 8`, reset low for 2 edges then high. After 3 edges `topOfStack1..3 = 0x1111, 0x2222, 0x3333` and `finished = 1`. Before edge 3, `finished = 0`.
- Per-edge check, same stimulus:
  - After edge 1: only `topOfStack1 = 0x1111`.
  - After edge 2: `topOfStack2 = 0x2222` added.
  - `address` sequence across the fetch: 8 during reset, then 9, 10, 10.
- Wrap-around: `stackPointer = 0xFFFF`, `ram[0xFFFF] = 0xAAAA`, `ram[0] = 0xBBBB`, `ram[1] = 0xCCCC`. Result is `0xAAAA, 0xBBBB, 0xCCCC`, `finished = 1`.
- Reset mid-fetch: pull reset low after edge 1. All outputs read 0 before the next edge. Change `stackPointer` to 20 (`ram[20..22] = 1, 2, 3`) and release. Result is `1, 2, 3` three edges later.
- Hold in DONE: after `finished`, change RAM contents and run 10 more cycles. Outputs and `finished` are unchanged.
- Reset values: reset low with no prior fetch. `topOfStack1..3 = 0`, `finished = 0`, `address = stackPointer`.
